// File: rtl/vga_object_sync.sv
// -----------------------------------------------------------------------------
// vga_object_sync
//   640x480@60 Hz VGA timing generator with a small object renderer. Up to
//   NUM_OBJ solid squares are drawn over a black background from a write-only
//   register table (three 16-bit words per object). A sticky frame interrupt is
//   raised at the start of vertical sync.
//
// Ports:
//   clk_50_mhz  in   system clock (50 MHz); pixel rate is half of it
//   rst         in   synchronous active-high reset
//   wren        in   register write strobe
//   addr[5:0]   in   register index (object i uses 3i, 3i+1, 3i+2)
//   ldr[15:0]   in   write data
//   ack         in   interrupt acknowledge, clears IRQ_Vsync
//   rgb[2:0]    out  {red, green, blue}, registered
//   hsync       out  active-low horizontal sync, registered
//   vsync       out  active-low vertical sync, registered
//   IRQ_Vsync   out  frame interrupt, level, sticky until ack
//
// Build option:
//   VGA_BORDER_EN  when defined, the outermost visible rows/columns are forced
//                  to white as a monitor alignment aid.
// -----------------------------------------------------------------------------
module vga_object_sync #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int NUM_OBJ   = 12
) (
  input  logic        clk_50_mhz,
  input  logic        rst,
  input  logic        wren,
  input  logic [5:0]  addr,
  input  logic [15:0] ldr,
  input  logic        ack,
  output logic [2:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        IRQ_Vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HC_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HC_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] VC_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  // Last line before vsync: the wrap out of this line enters the sync pulse.
  localparam logic [9:0] VC_PRE_VS = 10'(V_VISIBLE + V_FRONT - 1);

  logic               r_tick;
  logic [9:0]         r_hc;
  logic [9:0]         r_vc;
  logic [NUM_OBJ-1:0] w_hit;
  logic [2:0]         w_obj_col [NUM_OBJ];
  logic [2:0]         w_obj_rgb;
  logic [2:0]         w_pix_rgb;
  logic               w_visible;
  logic               w_border;
  logic               w_irq_set;
  logic               w_unused;

  // ldr[15:10] carries no register bits.
  assign w_unused = ^ldr[15:10];

  // ---------------------------------------------------------------------------
  // Object table and per-object hit test. Each object owns its registers, so
  // the write decode is a plain address match per field.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [2:0]  r_col;
    logic [5:0]  r_size;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;

    always_ff @(posedge clk_50_mhz) begin
      if (rst) begin
        r_x    <= '0;
        r_y    <= '0;
        r_col  <= '0;
        r_size <= '0;
      end else if (wren) begin
        if (addr == 6'(3 * gi))     r_x <= ldr[9:0];
        if (addr == 6'(3 * gi + 1)) r_y <= ldr[8:0];
        if (addr == 6'(3 * gi + 2)) begin
          r_col  <= ldr[2:0];
          r_size <= ldr[8:3];
        end
      end
    end

    // 11-bit sums: an object running past the right edge simply clips.
    assign w_x_end = {1'b0, r_x} + {5'b0, r_size};
    assign w_y_end = {2'b0, r_y} + {5'b0, r_size};

    assign w_hit[gi] = (r_size != 6'd0)
                    && ({1'b0, r_hc} >= {1'b0, r_x}) && ({1'b0, r_hc} < w_x_end)
                    && ({1'b0, r_vc} >= {2'b0, r_y}) && ({1'b0, r_vc} < w_y_end);
    assign w_obj_col[gi] = r_col;
  end

  // Lowest index wins: scan downwards so lower objects overwrite higher ones.
  always_comb begin
    w_obj_rgb = 3'b000;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (w_hit[i]) w_obj_rgb = w_obj_col[i];
    end
  end

  assign w_visible = (r_hc < HC_VIS) && (r_vc < VC_VIS);

`ifdef VGA_BORDER_EN
  localparam logic [9:0] HC_RIGHT  = 10'(H_VISIBLE - 1);
  localparam logic [9:0] VC_BOTTOM = 10'(V_VISIBLE - 1);
  assign w_border = (r_hc == 10'd0) || (r_hc == HC_RIGHT)
                 || (r_vc == 10'd0) || (r_vc == VC_BOTTOM);
`else
  assign w_border = 1'b0;
`endif

  always_comb begin
    w_pix_rgb = 3'b000;
    if (w_visible) w_pix_rgb = w_border ? 3'b111 : w_obj_rgb;
  end

  // Set on the pixel tick that moves the counters to (hc=0, vc=VS_START).
  assign w_irq_set = r_tick && (r_hc == HC_LAST) && (r_vc == VC_PRE_VS);

  // ---------------------------------------------------------------------------
  // Counters, registered video outputs and interrupt.
  // Outputs are computed from the counters before they advance, giving one
  // pixel of latency on rgb, hsync and vsync alike.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      r_tick    <= 1'b0;
      r_hc      <= '0;
      r_vc      <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      rgb       <= 3'b000;
      IRQ_Vsync <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (r_tick) begin
        hsync <= !((r_hc >= HS_START) && (r_hc <= HS_END));
        vsync <= !((r_vc >= VS_START) && (r_vc <= VS_END));
        rgb   <= w_pix_rgb;
        if (r_hc == HC_LAST) begin
          r_hc <= '0;
          r_vc <= (r_vc == VC_LAST) ? 10'd0 : r_vc + 10'd1;
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
      if (w_irq_set)  IRQ_Vsync <= 1'b1;
      else if (ack)   IRQ_Vsync <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_object_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_object_sync
//   Two instances share all inputs: u_small uses shrunken timing (80x30 total)
//   so whole frames, vsync and the interrupt fit in a short run; u_full uses
//   the real 800x525 timing for hsync width/period and the 640-pixel clip.
//   A behavioural model derives every output from the pixel index implied by
//   the number of clocks since reset, and a handful of literal checks pin it.
// -----------------------------------------------------------------------------
module tb_vga_object_sync;

  localparam int NOBJ  = 12;
  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVV = 24, SVF = 2, SVS = 2, SVB = 2;
  localparam int S_HT  = 80;
  localparam int S_FT  = 2400;
  localparam int S_IRQ = 2080;    // (24+2)*80 ticks into the frame
  localparam int F_HT  = 800;
  localparam int F_FT  = 420000;
  localparam int F_IRQ = 392000;  // (480+10)*800

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wren = 1'b0;
  logic        ack = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] ldr = '0;
  logic [2:0]  rgb_s, rgb_f;
  logic        hsync_s, vsync_s, irq_s;
  logic        hsync_f, vsync_f, irq_f;

  always #5 clk = ~clk;

  vga_object_sync #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .NUM_OBJ(NOBJ)
  ) u_small (
    .clk_50_mhz(clk), .rst(rst), .wren(wren), .addr(addr), .ldr(ldr),
    .ack(ack), .rgb(rgb_s), .hsync(hsync_s), .vsync(vsync_s), .IRQ_Vsync(irq_s)
  );

  vga_object_sync u_full (
    .clk_50_mhz(clk), .rst(rst), .wren(wren), .addr(addr), .ldr(ldr),
    .ack(ack), .rgb(rgb_f), .hsync(hsync_f), .vsync(vsync_f), .IRQ_Vsync(irq_f)
  );

  // ---------------------------------------------------------------- model ---
  int         m_x [NOBJ];
  int         m_y [NOBJ];
  int         m_sz[NOBJ];
  logic [2:0] m_col[NOBJ];
  int         m_k = 0;                 // clocks since the last reset edge
  logic [4:0] e_s = 5'b11000;          // {hsync, vsync, rgb}
  logic [4:0] e_f = 5'b11000;
  logic       e_irq_s = 1'b0;
  logic       e_irq_f = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      if (n_fail >= 500) finish_test();
    end
  endtask

  // Expected {hsync, vsync, rgb} for pixel number p counted from frame start.
  function automatic logic [4:0] exp_pix(input int p, input int hv, input int hf,
                                         input int hs, input int hb, input int vv,
                                         input int vf, input int vs, input int vb);
    int         htot = hv + hf + hs + hb;
    int         vtot = vv + vf + vs + vb;
    int         hc = p % htot;
    int         vc = (p / htot) % vtot;
    logic       h_o, v_o;
    logic [2:0] c;
    bit         found;
    h_o = !(hc >= hv + hf && hc < hv + hf + hs);
    v_o = !(vc >= vv + vf && vc < vv + vf + vs);
    c = 3'b000;
    found = 0;
    if (hc < hv && vc < vv) begin
      for (int i = 0; i < NOBJ; i++) begin
        if (!found && m_sz[i] != 0 && hc >= m_x[i] && hc < m_x[i] + m_sz[i]
            && vc >= m_y[i] && vc < m_y[i] + m_sz[i]) begin
          c = m_col[i];
          found = 1;
        end
      end
`ifdef VGA_BORDER_EN
      if (hc == 0 || hc == hv - 1 || vc == 0 || vc == vv - 1) c = 3'b111;
`endif
    end
    return {h_o, v_o, c};
  endfunction

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      m_k = 0;
      e_s = 5'b11000;
      e_f = 5'b11000;
      e_irq_s = 0;
      e_irq_f = 0;
      for (int i = 0; i < NOBJ; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_sz[i] = 0; m_col[i] = 3'b000;
      end
    end else begin
      m_k++;
      // Every second clock is a pixel tick; it shows the pixel before it.
      if (m_k % 2 == 0) begin
        e_s = exp_pix(m_k / 2 - 1, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
        e_f = exp_pix(m_k / 2 - 1, 640, 16, 96, 48, 480, 10, 2, 33);
      end
      if (m_k % 2 == 0 && (m_k / 2) % S_FT == S_IRQ) e_irq_s = 1;
      else if (ack) e_irq_s = 0;
      if (m_k % 2 == 0 && (m_k / 2) % F_FT == F_IRQ) e_irq_f = 1;
      else if (ack) e_irq_f = 0;
      // Table updates after the pixel: a write shows on the next pixel.
      if (wren && addr < 6'd36) begin
        idx = int'(addr) / 3;
        case (int'(addr) % 3)
          0: m_x[idx] = int'(ldr[9:0]);
          1: m_y[idx] = int'(ldr[8:0]);
          default: begin
            m_col[idx] = ldr[2:0];
            m_sz[idx]  = int'(ldr[8:3]);
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------- compare process ---
  always @(negedge clk) begin
    if (chk_en) begin
      check("s_hsync", hsync_s, e_s[4]);
      check("s_vsync", vsync_s, e_s[3]);
      check("s_rgb",   rgb_s,   e_s[2:0]);
      check("s_irq",   irq_s,   e_irq_s);
      check("f_hsync", hsync_f, e_f[4]);
      check("f_vsync", vsync_f, e_f[3]);
      check("f_rgb",   rgb_f,   e_f[2:0]);
      check("f_irq",   irq_f,   e_irq_f);
    end
  end

  // ------------------------------------------- literal timing measurements ---
  int f_run = 0, f_last_fall = 0, s_vrun = 0, s_last_vfall = 0;
  bit prev_hs_f = 1, prev_hs_s = 1, prev_vs_s = 1, pend_s = 0, pend_f = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_k == 0) begin
        f_run = 0; f_last_fall = 0; s_vrun = 0; s_last_vfall = 0;
        prev_hs_f = 1; prev_hs_s = 1; prev_vs_s = 1;
        pend_s = 1; pend_f = 1;
      end else begin
        if (pend_s && prev_hs_s && !hsync_s) begin
          check("s_first_hsync_fall_clk", m_k, 138);   // pixel 68 -> tick 69
          pend_s = 0;
        end
        if (pend_f && prev_hs_f && !hsync_f) begin
          check("f_first_hsync_fall_clk", m_k, 1314);  // pixel 656 -> tick 657
          pend_f = 0;
        end
        if (!hsync_f) f_run++;
        if (prev_hs_f && !hsync_f) begin
          if (f_last_fall > 0) check("f_hsync_period", m_k - f_last_fall, 1600);
          f_last_fall = m_k;
        end
        if (!prev_hs_f && hsync_f) begin
          check("f_hsync_low_clks", f_run, 192);
          f_run = 0;
        end
        if (!vsync_s) s_vrun++;
        if (prev_vs_s && !vsync_s) begin
          if (s_last_vfall > 0) check("s_vsync_period", m_k - s_last_vfall, 4800);
          s_last_vfall = m_k;
        end
        if (!prev_vs_s && vsync_s) begin
          check("s_vsync_low_clks", s_vrun, 320);
          s_vrun = 0;
        end
        prev_hs_f = hsync_f;
        prev_hs_s = hsync_s;
        prev_vs_s = vsync_s;
      end
    end
  end

  // ---------------------------------------------------------------- tasks ---
  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    wren = 1'b1; addr = a; ldr = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Returns on the first clock the given pixel is on the outputs.
  task automatic wait_pix(input bit full, input int hc, input int vc, output bit ok);
    int tgt = full ? vc * F_HT + hc : vc * S_HT + hc;
    int ft  = full ? F_FT : S_FT;
    ok = 0;
    for (int n = 0; n < 12000 && !ok; n++) begin
      @(negedge clk);
      if (m_k >= 2 && ((m_k / 2 - 1) % ft) == tgt) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pix(%0d,%0d): pixel not reached, got timeout, expected display", hc, vc);
    end
  endtask

  task automatic pix(input string name, input bit full, input int hc, input int vc,
                     input logic [2:0] exp);
    bit ok;
    wait_pix(full, hc, vc, ok);
    if (ok) check(name, full ? rgb_f : rgb_s, exp);
  endtask

  task automatic wait_irq();
    for (int n = 0; n < 6000 && irq_s !== 1'b1; n++) @(negedge clk);
    check("irq_next_frame", irq_s, 1);
  endtask

  // -------------------------------------------------------------- stimulus ---
  initial begin
    bit ok;
    int y_f;
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    check("rst_hsync", hsync_s, 1);
    check("rst_vsync", vsync_s, 1);
    check("rst_rgb",   rgb_s,   0);
    check("rst_irq",   irq_s,   0);
    check("rst_f_hsync", hsync_f, 1);
    rst = 1'b0;

    // First frame with no objects; irq is set at clock 4160.
    repeat (5000) @(negedge clk);
    check("irq_frame1", irq_s, 1);
    repeat (1000) @(negedge clk);
    check("irq_held_1000", irq_s, 1);
    ack_pulse();
    check("irq_ack_clear", irq_s, 0);
    wait_irq();
    ack_pulse();
    check("irq_ack_clear2", irq_s, 0);
    // Assert ack on exactly the clock that sets the interrupt.
    ok = 0;
    for (int n = 0; n < 6000 && !ok; n++) begin
      @(negedge clk);
      if ((m_k + 1) % 2 == 0 && ((m_k + 1) / 2) % S_FT == S_IRQ) ok = 1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL irq_coincide: set edge not found, got timeout, expected edge");
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("irq_set_wins", irq_s, 1);
    check("f_irq_quiet", irq_f, 0);
    ack_pulse();

    // Right-edge clip on the full-size timing, a couple of lines ahead.
    y_f = (m_k / 2) / F_HT + 2;
    wr(6'd9,  16'd636);
    wr(6'd10, 16'(y_f));
    wr(6'd11, 16'h0085);                 // size 16, colour 5
    pix("f_clip_635", 1, 635, y_f, 3'b000);
    pix("f_clip_636", 1, 636, y_f, 3'b101);
    pix("f_clip_639", 1, 639, y_f, 3'b101);
    pix("f_clip_640", 1, 640, y_f, 3'b000);
    pix("f_nowrap_0", 1, 0,  y_f + 1, 3'b000);
    pix("f_nowrap_11", 1, 11, y_f + 1, 3'b000);

    // Single object: x=10, y=5, size 4, colour 4.
    wr(6'd0, 16'd10);
    wr(6'd1, 16'd5);
    wr(6'd2, 16'h0024);
    pix("obj_10_4",  0, 10, 4, 3'b000);
    pix("obj_9_5",   0, 9,  5, 3'b000);
    pix("obj_10_5",  0, 10, 5, 3'b100);
    pix("obj_14_5",  0, 14, 5, 3'b000);
    pix("obj_13_8",  0, 13, 8, 3'b100);
    pix("obj_10_9",  0, 10, 9, 3'b000);

    // Overlap: obj0 (10,10) size 8 colour 1, obj1 (12,12) size 8 colour 2.
    wr(6'd1, 16'd10);
    wr(6'd2, 16'h0041);
    wr(6'd3, 16'd12);
    wr(6'd4, 16'd12);
    wr(6'd5, 16'h0042);
    pix("ovl_12_12", 0, 12, 12, 3'b001);
    pix("ovl_13_13", 0, 13, 13, 3'b001);
    pix("ovl_18_18", 0, 18, 18, 3'b010);
    pix("ovl_19_19", 0, 19, 19, 3'b010);

    // Clip on the small timing: obj2 x=60 size 16 colour 3.
    wr(6'd6, 16'd60);
    wr(6'd7, 16'd0);
    wr(6'd8, 16'h0083);
    pix("clip_59_0",  0, 59, 0,  3'b000);
    pix("clip_60_0",  0, 60, 0,  3'b011);
    pix("clip_63_0",  0, 63, 0,  3'b011);
    pix("clip_0_1",   0, 0,  1,  3'b000);
    pix("clip_11_1",  0, 11, 1,  3'b000);
    pix("clip_63_15", 0, 63, 15, 3'b011);
    pix("clip_60_16", 0, 60, 16, 3'b000);

    // Out-of-range addresses are ignored.
    wr(6'd40, 16'hFFFF);
    wr(6'd63, 16'hFFFF);
    pix("ign_30_20", 0, 30, 20, 3'b000);
    pix("ign_13_13", 0, 13, 13, 3'b001);

    // Reset in the middle of a line.
    wait_pix(0, 30, 12, ok);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_hsync", hsync_s, 1);
    check("mrst_vsync", vsync_s, 1);
    check("mrst_rgb",   rgb_s,   0);
    check("mrst_f_rgb", rgb_f,   0);
    rst = 1'b0;
    pix("mrst_obj_gone", 0, 13, 13, 3'b000);
    pix("mrst_clip_gone", 0, 60, 0, 3'b000);

    finish_test();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_object_sync.md
Name: vga_object_sync

Overview:
- 640x480@60 Hz VGA timing generator plus a small object renderer for the CPU's graphics window.
- The CPU writes a 36-word object table through a 6-bit register port, at CPU addresses 0x200–0x223 with addr = address[5:0].
- The block draws up to 12 solid coloured squares over a black background.
- It raises a frame interrupt (CPU IRQ7) at the start of vertical sync.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (total 800)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (total 525)
- NUM_OBJ, 12, number of objects (3 registers each)

Ports:
- clk_50_mhz input 1 — system clock, 50 MHz
- rst input 1 — synchronous, active-high reset
- wren input 1 — register write strobe
- addr input 6 — register index
- ldr input 16 — write data
- ack input 1 — interrupt acknowledge; clears IRQ_Vsync
- rgb output 3 — {red, green, blue}
- hsync output 1 — active-low horizontal sync
- vsync output 1 — active-low vertical sync
- IRQ_Vsync output 1 — frame interrupt request, level, sticky until ack

Behaviour:
- Pixel enable: a 1-bit toggle divides the clock by 2, giving a 25 MHz pixel tick. Counters advance only on tick cycles.
- hc counts 0..799 and wraps to 0. On the wrap, vc increments over 0..524 and wraps to 0.
- Visible region: hc < 640 and vc < 480.
- hsync = 0 when 656 ≤ hc ≤ 751, else 1.
- vsync = 0 when 490 ≤ vc ≤ 491, else 1.
- hsync, vsync and rgb are registered: they reflect the counter values of the previous tick, one pixel of latency, identical for all three outputs.
- Register map, object i = 0..11, base 3i:
  - base+0: bits[9:0] x
  - base+1: bits[8:0] y
  - base+2: bits[2:0] colour, bits[8:3] size in pixels (0 = object disabled)
  - Unused bits read as don't-care and are ignored.
- Writes:
  - On a clock with wren=1 and addr < 36, the register takes ldr on that edge.
  - addr 36..63 is ignored.
  - A write takes effect on the next pixel drawn.
  - The register file is write-only.
- Hit test: object i covers a pixel when size≠0, x ≤ hc < x+size, and y ≤ vc < y+size.
  - Comparisons are done in 11-bit arithmetic, so x+size ≥ 640 clips naturally with no wrap.
- rgb:
  - In the visible region, rgb is the colour of the lowest-index covering object, else 3'b000.
  - Outside the visible region, rgb = 3'b000.
- IRQ_Vsync:
  - Set on the tick where vc becomes 490 with hc = 0.
  - Cleared on any clock with ack=1.
  - If set and ack occur in the same clock, set wins.
- Reset:
  - hc, vc and the tick toggle go to 0.
  - hsync = 1, vsync = 1, rgb = 0, IRQ_Vsync = 0.
  - All object registers are cleared to 0, so all objects are disabled.
  - Reset mid-frame restarts the frame at (0,0) on the next clock.

Optional Feature:
- Macro VGA_BORDER_EN.
- When defined: visible pixels with hc = 0, hc = 639, vc = 0 or vc = 479 are forced to rgb 3'b111. This overrides objects and serves as a monitor alignment aid.
- When undefined: no border; behaviour exactly as above.

Test Plan:
- Reset, then run one full frame:
  - Hsync low for 192 clocks every 1600 clocks.
  - Vsync low for 3200 clocks every 840000 clocks.
  - IRQ_Vsync rises once per frame.
  - rgb stays 0 throughout.
- Write obj0 x=100, y=50, word2 = 0x0024 (size 4, colour 4):
  - rgb = 3'b100 exactly for hc 100..103, vc 50..53.
  - Black elsewhere.
- Overlap:
  - obj0 at (10,10), size 8, colour 1; obj1 at (12,12), size 8, colour 2.
  - Pixel (13,13) shows 3'b001.
  - Pixel (19,19) shows 3'b010.
- Clipping / ignored writes:
  - obj2 at x=636, size 16: only hc 636..639 are coloured and no wrap to hc 0..11.
  - A write to addr 40 changes nothing.
- IRQ handshake:
  - IRQ_Vsync is held through 1000 clocks without ack.
  - Pulsing ack=1 for one clock clears it.
  - It is set again on the next frame.
  - ack coincident with the set edge leaves IRQ_Vsync = 1.
- Reset mid-line at hc=300, vc=200:
  - Next cycle: hsync = vsync = 1, rgb = 0.
  - Counters restart at 0.
  - Previously configured objects are no longer drawn.
